microwave_oven: RTL and testbench

Control and display block for a microwave oven front panel. It accepts a 3-digit cook time from a 10-key one-hot keypad and starts, pauses and stops cooking from active-low push-buttons. It counts the time down once per second while driving the magnetron enable, and it outputs the M:SS time on three 7-segment digits. It sits between the panel I/O and the magnetron power stage.

---
 rtl/microwave_pkg.sv | 43 ++++
 rtl/bcd_to_7seg.sv | 20 ++
 rtl/microwave_oven.sv | 230 +++++++++++++++++++++++
 tb/tb_microwave_oven.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave oven front-panel controller:
// FSM state encoding, BCD digit type, 7-segment code table and keypad helpers.
package microwave_pkg;

    // Controller states: time entry, counting down, and held/paused.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOK  = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // One BCD display digit.
    typedef logic [3:0] bcd_t;

    // Segment patterns {g,f,e,d,c,b,a}, active-high, for digits 0..9.
    localparam logic [6:0] SEG_CODES [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // Pattern shown for a non-decimal nibble (cannot occur from keypad entry).
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Highest value the seconds-tens digit takes after a minute borrow.
    localparam bcd_t TENS_WRAP = 4'd5;

    // Highest value of a decimal digit, used on an ones-digit borrow.
    localparam bcd_t ONES_WRAP = 4'd9;

    // Convert a one-hot keypad code into the digit it represents.
    // Only meaningful when exactly one bit is set; the caller checks that.
    function automatic bcd_t onehot_to_bcd(input logic [9:0] keys);
        bcd_t digit;
        digit = '0;
        for (int i = 0; i < 10; i++) begin
            if (keys[i]) begin
                digit = i[3:0];
            end
        end
        return digit;
    endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to 7-segment decoder, segments {g,f,e,d,c,b,a} active-high.
// Nibbles above 9 blank the digit.
module bcd_to_7seg
    import microwave_pkg::*;
(
    input  bcd_t       digit,
    output logic [6:0] segs
);

    // Table lookup of the segment pattern for the incoming digit.
    always_comb begin
        segs = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (digit == i[3:0]) begin
                segs = SEG_CODES[i];
            end
        end
    end

endmodule

// File: rtl/microwave_oven.sv
// Microwave oven front-panel controller: keypad time entry, START/STOP/door
// FSM, once-per-second BCD countdown and three 7-segment digit outputs.
// Optional feature: define DOOR_AUTO_RESUME_EN to let a door re-close resume
// cooking when the pause was caused by opening the door.
module microwave_oven
    import microwave_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50
) (
    input  logic       clk,
    input  logic       clearn,
    input  logic [9:0] keypad,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    output logic       mag,
    output logic [6:0] sec_ones_segs,
    output logic [6:0] sec_tens_segs,
    output logic [6:0] min_segs
);

    // Prescaler width; TICKS_PER_SEC >= 2 so this is at least one bit.
    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] presc;
    logic [9:0]    key_prev;
    bcd_t          min_d;
    bcd_t          tens_d;
    bcd_t          ones_d;

    logic          key_hit;
    logic          time_zero;
    logic          cook_run;
    logic          sec_tick;
    logic          last_sec;
    logic          cook_entry;
    logic          clear_time;

`ifdef DOOR_AUTO_RESUME_EN
    logic          door_prev;
    logic          pause_door;
    logic          door_rise;
`endif

    // ------------------------------------------------------------------
    // Qualifiers shared by the FSM and the datapath
    // ------------------------------------------------------------------

    // A key registers only in IDLE, on the transition from no key to a single key.
    assign key_hit    = (state == IDLE) && (key_prev == '0) && $onehot(keypad);
    assign time_zero  = (min_d == '0) && (tens_d == '0) && (ones_d == '0);

    // COOK cycles that actually keep cooking (no stop request, door shut);
    // on any other COOK cycle the FSM leaves for PAUSE and time is frozen.
    assign cook_run   = (state == COOK) && stopn && door_closed;
    assign sec_tick   = cook_run && (presc == PRESC_LAST);
    assign last_sec   = sec_tick && (min_d == '0) && (tens_d == '0) && (ones_d == 4'd1);
    assign cook_entry = (state_next == COOK) && (state != COOK);
    assign clear_time = (state == PAUSE) && !stopn;

`ifdef DOOR_AUTO_RESUME_EN
    assign door_rise  = door_closed && !door_prev;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register; clearn returns the panel to time entry.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; STOP always wins over START when both are pressed.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (stopn && !startn && door_closed && !time_zero) begin
                    state_next = COOK;
                end
            end
            COOK: begin
                if (!stopn || !door_closed) begin
                    state_next = PAUSE;
                end else if (last_sec) begin
                    state_next = IDLE;
                end
            end
            PAUSE: begin
                if (!stopn) begin
                    state_next = IDLE;
                end else if (!startn && door_closed) begin
                    state_next = COOK;
`ifdef DOOR_AUTO_RESUME_EN
                end else if (pause_door && door_rise) begin
                    state_next = COOK;
`endif
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Magnetron enable; the door switch gates it directly so opening the
    // door kills power without waiting for a clock edge.
    always_comb begin
        mag = (state == COOK) && door_closed;
    end

`ifdef DOOR_AUTO_RESUME_EN
    // Remember the door level and whether the current pause came from the door.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            door_prev  <= 1'b0;
            pause_door <= 1'b0;
        end else begin
            door_prev <= door_closed;
            if (state == COOK && state_next == PAUSE) begin
                pause_door <= stopn && !door_closed;
            end else if (state != PAUSE) begin
                pause_door <= 1'b0;
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Keypad edge register
    // ------------------------------------------------------------------

    // Previous keypad sample; a held key or a chord must return to all-zero
    // before another digit can register.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            key_prev <= '0;
        end else begin
            key_prev <= keypad;
        end
    end

    // ------------------------------------------------------------------
    // One-second prescaler
    // ------------------------------------------------------------------

    // Counts cooking cycles; restarts on every entry into COOK so the first
    // decrement lands a full second after START.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            presc <= '0;
        end else if (cook_entry) begin
            presc <= '0;
        end else if (cook_run) begin
            if (sec_tick) begin
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // BCD time register: key shift-in and countdown
    // ------------------------------------------------------------------

    // Time digits: cleared by STOP from PAUSE, shifted left on a key, and
    // decremented with borrow (ones 0->9, tens 0->5) once per second.
    always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) begin
            min_d  <= '0;
            tens_d <= '0;
            ones_d <= '0;
        end else if (clear_time) begin
            min_d  <= '0;
            tens_d <= '0;
            ones_d <= '0;
        end else if (key_hit) begin
            min_d  <= tens_d;
            tens_d <= ones_d;
            ones_d <= onehot_to_bcd(keypad);
        end else if (sec_tick) begin
            if (ones_d != '0) begin
                ones_d <= ones_d - 4'd1;
            end else begin
                ones_d <= ONES_WRAP;
                if (tens_d != '0) begin
                    tens_d <= tens_d - 4'd1;
                end else begin
                    tens_d <= TENS_WRAP;
                    min_d  <= min_d - 4'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Display decoders
    // ------------------------------------------------------------------

    bcd_t       disp_digit [3];
    logic [6:0] disp_segs  [3];

    assign disp_digit[0] = ones_d;
    assign disp_digit[1] = tens_d;
    assign disp_digit[2] = min_d;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_digit
            bcd_to_7seg u_dec (
                .digit (disp_digit[gi]),
                .segs  (disp_segs[gi])
            );
        end
    endgenerate

    assign sec_ones_segs = disp_segs[0];
    assign sec_tens_segs = disp_segs[1];
    assign min_segs      = disp_segs[2];

endmodule

// File: tb/tb_microwave_oven.sv
// Self-checking bench for microwave_oven: directed panel scenarios followed by
// randomized cook times checked against a seconds-based reference model.
module tb_microwave_oven;

    localparam int T = 50;

    logic       clk = 1'b0;
    logic       clearn;
    logic [9:0] keypad;
    logic       startn;
    logic       stopn;
    logic       door_closed;
    logic       mag;
    logic [6:0] sec_ones_segs;
    logic [6:0] sec_tens_segs;
    logic [6:0] min_segs;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] seg_ref [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    always #5 clk = ~clk;

    microwave_oven #(.TICKS_PER_SEC(T)) dut (
        .clk           (clk),
        .clearn        (clearn),
        .keypad        (keypad),
        .startn        (startn),
        .stopn         (stopn),
        .door_closed   (door_closed),
        .mag           (mag),
        .sec_ones_segs (sec_ones_segs),
        .sec_tens_segs (sec_tens_segs),
        .min_segs      (min_segs)
    );

    task automatic check_seg(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    // Compare the whole display (M:SS digits) and the magnetron enable.
    task automatic check_disp(input string tag, input int m, input int t, input int o, input logic exp_mag);
        check_seg({tag, "/min"},  min_segs,      seg_ref[m]);
        check_seg({tag, "/tens"}, sec_tens_segs, seg_ref[t]);
        check_seg({tag, "/ones"}, sec_ones_segs, seg_ref[o]);
        check_bit({tag, "/mag"},  mag,           exp_mag);
    endtask

    // Same check with the expected display derived from a seconds count.
    task automatic check_secs(input string tag, input int secs, input logic exp_mag);
        check_disp(tag, secs / 60, (secs % 60) / 10, secs % 10, exp_mag);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int d);
        keypad = 10'(1) << d;
        @(negedge clk);
        keypad = '0;
        @(negedge clk);
        $display("key %0d pressed", d);
    endtask

    task automatic pulse_start();
        startn = 1'b0;
        @(negedge clk);
        startn = 1'b1;
        $display("START pulsed");
    endtask

    task automatic pulse_stop();
        stopn = 1'b0;
        @(negedge clk);
        stopn = 1'b1;
        $display("STOP pulsed");
    endtask

    task automatic to_idle();
        pulse_stop();
        pulse_stop();
    endtask

    initial begin
        int m, t, o, secs, k;

        clearn      = 1'b1;
        keypad      = '0;
        startn      = 1'b1;
        stopn       = 1'b1;
        door_closed = 1'b1;

        // Reset state
        #2 clearn = 1'b0;
        #1 check_disp("reset", 0, 0, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        clearn = 1'b1;
        @(negedge clk);
        check_disp("after_reset", 0, 0, 0, 1'b0);

        // Key entry 2,5,4
        press(2);
        check_disp("key_2", 0, 0, 2, 1'b0);
        press(5);
        press(4);
        check_disp("keys_254", 2, 5, 4, 1'b0);

        // Start and first decrement exactly one second later
        pulse_start();
        check_disp("start_254", 2, 5, 4, 1'b1);
        cycles(T - 1);
        check_disp("pre_tick_254", 2, 5, 4, 1'b1);
        cycles(1);
        check_disp("tick_253", 2, 5, 3, 1'b1);

        // STOP -> PAUSE holds, second STOP clears
        pulse_stop();
        check_disp("pause_hold", 2, 5, 3, 1'b0);
        cycles(T + 10);
        check_disp("pause_frozen", 2, 5, 3, 1'b0);
        pulse_stop();
        check_disp("stop_clear", 0, 0, 0, 1'b0);

        // Borrow 1:00 -> 0:59
        press(1); press(0); press(0);
        check_disp("keys_100", 1, 0, 0, 1'b0);
        pulse_start();
        cycles(T);
        check_disp("borrow_059", 0, 5, 9, 1'b1);
        to_idle();
        check_disp("idle_after_borrow", 0, 0, 0, 1'b0);

        // Completion 0:02 -> 0:00 and START ignored at zero
        press(0); press(0); press(2);
        pulse_start();
        cycles(T);
        check_disp("done_001", 0, 0, 1, 1'b1);
        cycles(T - 1);
        check_disp("done_pre_zero", 0, 0, 1, 1'b1);
        cycles(1);
        check_disp("done_zero", 0, 0, 0, 1'b0);
        pulse_start();
        check_disp("start_at_zero", 0, 0, 0, 1'b0);
        cycles(T + 2);
        check_disp("still_zero", 0, 0, 0, 1'b0);

        // Door opened mid-cook: mag drops at once, time frozen, needs START
        press(0); press(0); press(9);
        pulse_start();
        cycles(5);
        door_closed = 1'b0;
        #1 check_bit("door_open_mag", mag, 1'b0);
        @(negedge clk);
        door_closed = 1'b1;
        #1 check_disp("door_reclosed", 0, 0, 9, 1'b0);
        cycles(2 * T);
        check_disp("door_no_resume", 0, 0, 9, 1'b0);
        pulse_start();
        check_disp("door_restart", 0, 0, 9, 1'b1);
        cycles(T - 1);
        check_disp("door_pre_tick", 0, 0, 9, 1'b1);
        cycles(1);
        check_disp("door_tick_008", 0, 0, 8, 1'b1);

        // Asynchronous clear while cooking
        #2 clearn = 1'b0;
        #1 check_disp("clear_mid_cook", 0, 0, 0, 1'b0);
        @(negedge clk);
        clearn = 1'b1;
        @(negedge clk);

        // Tens above 5 accepted, counts down from there
        press(0); press(7); press(5);
        check_disp("keys_075", 0, 7, 5, 1'b0);
        pulse_start();
        cycles(T);
        check_disp("tick_074", 0, 7, 4, 1'b1);
        to_idle();

        // Held key shifts once; chord 0x024 ignored; keys ignored in COOK
        keypad = 10'(1) << 3;
        cycles(4);
        keypad = '0;
        @(negedge clk);
        check_disp("held_key", 0, 0, 3, 1'b0);
        keypad = 10'h024;
        @(negedge clk);
        keypad = '0;
        @(negedge clk);
        $display("chord 0x024 pressed");
        check_disp("chord_ignored", 0, 0, 3, 1'b0);
        pulse_start();
        press(6);
        check_disp("key_in_cook", 0, 0, 3, 1'b1);
        to_idle();

        // START with door open, and START+STOP together, both refused in IDLE
        press(5);
        door_closed = 1'b0;
        pulse_start();
        door_closed = 1'b1;
        cycles(T + 2);
        check_disp("start_door_open", 0, 0, 5, 1'b0);
        startn = 1'b0;
        stopn  = 1'b0;
        @(negedge clk);
        startn = 1'b1;
        stopn  = 1'b1;
        $display("START+STOP pulsed");
        cycles(T + 1);
        check_disp("start_stop_both", 0, 0, 5, 1'b0);

        // Randomized cook times against the seconds model
        for (int it = 0; it < 6; it++) begin
            m = int'($urandom_range(0, 9));
            t = int'($urandom_range(0, 5));
            o = int'($urandom_range(0, 9));
            press(m); press(t); press(o);
            secs = m * 60 + t * 10 + o;
            $display("random %0d: %0d:%0d%0d", it, m, t, o);
            check_secs("rnd_entry", secs, 1'b0);
            if (secs > 0) begin
                pulse_start();
                check_secs("rnd_start", secs, 1'b1);
                k = int'($urandom_range(1, (secs < 4) ? secs : 4));
                for (int j = 0; j < k; j++) begin
                    cycles(T);
                    secs--;
                    check_secs("rnd_tick", secs, secs != 0);
                end
            end
            to_idle();
            check_secs("rnd_idle", 0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
